alsu_param: RTL
===============

ALSU_PARAM -- requirements
Module: alsu_param

Interface
REQ-001 Parameter WIDTH, default 3: operand width in bits; out is 2*WIDTH bits.
REQ-002 Parameter INPUT_PRIORITY, default 0: 0 = A wins, 1 = B wins, when both bypass or both reduction flags are set.
REQ-003 Parameter FULL_ADDER, default 1: 1 = cin is added in ADD, 0 = cin is ignored.
REQ-004 Parameter BLINK_DIV, default 4: number of cycles between leds inversions while an error is latched; minimum 1.
REQ-005 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: reset is synchronous and active-high.
REQ-007 Ports in_valid (input, 1) and in_ready (output, 1): request handshake; a command is accepted in a cycle where both are 1.
REQ-008 Ports A and B, input, WIDTH each: operands.
REQ-009 Port opcode, input, 3: 000 AND, 001 XOR, 010 ADD, 011 MUL, 100 SHIFT, 101 ROTATE, 110/111 invalid.
REQ-010 Ports cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B, each input, 1: operation modifiers.
REQ-011 Port shamt, input, clog2(2*WIDTH): step count for SHIFT/ROTATE.
REQ-012 Port out, output, 2*WIDTH: result register. Port out_valid, output, 1: one-cycle pulse when out updates.
REQ-013 Port err, output, 1: set with out_valid on invalid commands. Port leds, output, 16: error indicator.

Function
REQ-014 All inputs are captured into an input register only on acceptance; no operation uses unregistered inputs.
REQ-015 FSM states are IDLE, EXEC, STEP; in_ready = 1 only in IDLE.
REQ-016 IDLE -> EXEC on acceptance; EXEC -> IDLE for non-shift commands, and for SHIFT/ROTATE with shamt 0; EXEC -> STEP for SHIFT/ROTATE with shamt > 0; STEP -> IDLE after shamt steps.
REQ-017 Non-shift latency: out and out_valid update at the end of EXEC, i.e. 2 cycles after the acceptance edge; sustained throughput is 1 command per 2 cycles.
REQ-018 Priority in EXEC: invalid command, then bypass, then opcode.
REQ-019 A command is invalid if opcode is 11x, or if (red_op_A | red_op_B) and opcode is not AND/XOR.
REQ-020 Invalid command: out <= 0, err = 1 with out_valid, and the error latch is set.
REQ-021 Bypass: both set selects the operand chosen by INPUT_PRIORITY; otherwise the set one is selected; the result is zero-extended.
REQ-022 AND/XOR: a reduction flag (INPUT_PRIORITY on tie) gives the 1-bit reduction of that operand, zero-extended; otherwise the bitwise result, zero-extended.
REQ-023 ADD: A + B + (FULL_ADDER ? cin : 0), computed at 2*WIDTH with no truncation.
REQ-024 MUL: unsigned A * B at full 2*WIDTH.
REQ-025 SHIFT step: direction 1 gives {serial_in, out[2W-1:1]}; direction 0 gives {out[2W-2:0], serial_in}; serial_in is the registered value.
REQ-026 ROTATE step: direction 1 rotates left by 1; direction 0 rotates right by 1.
REQ-027 One step is applied per cycle in STEP, acting on the current out; out_valid pulses once, in the final step cycle.
REQ-028 SHIFT/ROTATE with shamt 0 leaves out unchanged and pulses out_valid at the end of EXEC.
REQ-029 The error latch clears when a valid command completes, and leds are then driven to 0 in the same cycle.
REQ-030 While the error latch is set, leds invert every BLINK_DIV cycles, starting from all-ones on the cycle the latch sets.
REQ-031 A new invalid command while the latch is set restarts the blink counter; leds go to all-ones.

Reset
REQ-032 rst has priority over every other event, including mid-STEP and a simultaneous handshake: state returns to IDLE, and out, out_valid, err, leds, the input register, the step counter, the blink counter and the error latch all go to 0.
REQ-033 in_ready is 1 in the first cycle after rst deasserts.

Structure
REQ-034 Shared package alsu_pkg holds the opcode constants and the FSM state typedef.
REQ-035 The leds blink counter is sub-module alsu_blink (inputs set/clear, output 16-bit leds); everything else stays in alsu_param.

Verification (WIDTH=3, defaults)
REQ-036 ADD A=7, B=7, cin=1 -> out=15 two cycles after accept, out_valid pulse, err=0.
REQ-037 MUL A=5, B=6 back-to-back with AND A=6, B=3 -> out=30, then out=2; in_ready=0 in each EXEC cycle.
REQ-038 With out=000001: SHIFT dir=0, serial_in=1, shamt=3 -> in_ready low 4 cycles, final out=001111, single out_valid pulse.
REQ-039 opcode=010 with red_op_A=1 -> out=0, err=1, leds=FFFF, then 0000 after 4 cycles; a subsequent valid XOR clears leds to 0.
REQ-040 rst asserted during STEP of ROTATE shamt=5 -> next cycle out=0, leds=0, in_ready=1, no out_valid.

Source files
------------

// File: rtl/alsu_pkg.sv
// Shared opcode encodings, FSM state type and command validity rule for the ALSU.
// Imported by the datapath top and the LED blink helper.
package alsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_STEP = 2'd2
   } state_e;

   localparam logic [2:0] OP_AND    = 3'b000;
   localparam logic [2:0] OP_XOR    = 3'b001;
   localparam logic [2:0] OP_ADD    = 3'b010;
   localparam logic [2:0] OP_MUL    = 3'b011;
   localparam logic [2:0] OP_SHIFT  = 3'b100;
   localparam logic [2:0] OP_ROTATE = 3'b101;

   localparam int LED_W = 16;

   // Reduction flags only make sense for the bitwise ops; 11x has no operation.
   function automatic logic cmd_invalid(input logic [2:0] op,
                                        input logic       red_a,
                                        input logic       red_b);
      return (op[2:1] == 2'b11) ||
             ((red_a | red_b) && (op != OP_AND) && (op != OP_XOR));
   endfunction

endpackage

// File: rtl/alsu_blink.sv
// Error LED blinker: holds the error latch, all-ones on set, inverts every BLINK_DIV cycles.
// One-cycle registered response to set/clear; no backpressure.
module alsu_blink
   import alsu_pkg::*;
#(
   parameter int BLINK_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_i,
   input  logic             clear_i,
   output logic [LED_W-1:0] leds_o
);

   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic             latch_q, latch_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [LED_W-1:0] leds_q,  leds_d;

   // A fresh set restarts the pattern even while already blinking.
   always_comb begin
      latch_d = latch_q;
      cnt_d   = cnt_q;
      leds_d  = leds_q;
      if (set_i) begin
         latch_d = 1'b1;
         cnt_d   = '0;
         leds_d  = '1;
      end else if (clear_i) begin
         latch_d = 1'b0;
         cnt_d   = '0;
         leds_d  = '0;
      end else if (latch_q) begin
         if (cnt_q == CW'(BLINK_DIV - 1)) begin
            cnt_d  = '0;
            leds_d = ~leds_q;
         end else begin
            cnt_d  = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         latch_q <= 1'b0;
         cnt_q   <= '0;
         leds_q  <= '0;
      end else begin
         latch_q <= latch_d;
         cnt_q   <= cnt_d;
         leds_q  <= leds_d;
      end
   end

   assign leds_o = leds_q;

endmodule

// File: rtl/alsu_param.sv
// Parameterised ALSU: registered command, result 2 cycles after accept, shifts/rotates one step per cycle.
// in_ready only in IDLE, so one command in flight at a time.
module alsu_param
   import alsu_pkg::*;
#(
   parameter int WIDTH          = 3,
   parameter int INPUT_PRIORITY = 0,
   parameter int FULL_ADDER     = 1,
   parameter int BLINK_DIV      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             A,
   input  logic [WIDTH-1:0]             B,
   input  logic [2:0]                   opcode,
   input  logic                         cin,
   input  logic                         serial_in,
   input  logic                         direction,
   input  logic                         red_op_A,
   input  logic                         red_op_B,
   input  logic                         bypass_A,
   input  logic                         bypass_B,
   input  logic [$clog2(2*WIDTH)-1:0]   shamt,
   output logic [2*WIDTH-1:0]           out,
   output logic                         out_valid,
   output logic                         err,
   output logic [LED_W-1:0]             leds
);

   localparam int OW = 2 * WIDTH;
   localparam int SW = $clog2(2 * WIDTH);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       opcode;
      logic             cin;
      logic             serial_in;
      logic             direction;
      logic             red_a;
      logic             red_b;
      logic             byp_a;
      logic             byp_b;
      logic [SW-1:0]    shamt;
   } cmd_t;

   state_e         state_q, state_d;
   cmd_t           cmd_q,   cmd_d;
   logic [OW-1:0]  out_q,   out_d;
   logic           out_valid_q, out_valid_d;
   logic           err_q,   err_d;
   logic [SW-1:0]  step_q,  step_d;
   logic           blink_set, blink_clr;

   logic           accept;
   logic           invalid;
   logic           bypass;
   logic           is_shift;
   logic           red_any;
   logic           red_pick_b;
   logic           cin_eff;
   logic [WIDTH-1:0] byp_val;
   logic [WIDTH-1:0] red_operand;
   logic [OW-1:0]  alu_res;
   logic [OW-1:0]  step_res;

   assign accept   = in_valid && (state_q == S_IDLE);
   assign invalid  = cmd_invalid(cmd_q.opcode, cmd_q.red_a, cmd_q.red_b);
   assign bypass   = cmd_q.byp_a | cmd_q.byp_b;
   assign is_shift = (cmd_q.opcode == OP_SHIFT) || (cmd_q.opcode == OP_ROTATE);
   assign red_any  = cmd_q.red_a | cmd_q.red_b;
   assign cin_eff  = (FULL_ADDER != 0) ? cmd_q.cin : 1'b0;

   // On a tie INPUT_PRIORITY decides; otherwise whichever flag is set wins.
   assign byp_val = (cmd_q.byp_a && cmd_q.byp_b) ? ((INPUT_PRIORITY != 0) ? cmd_q.b : cmd_q.a)
                                                 : (cmd_q.byp_a ? cmd_q.a : cmd_q.b);
   assign red_pick_b  = (cmd_q.red_a && cmd_q.red_b) ? (INPUT_PRIORITY != 0) : cmd_q.red_b;
   assign red_operand = red_pick_b ? cmd_q.b : cmd_q.a;

   always_comb begin
      alu_res = out_q;
      case (cmd_q.opcode)
         OP_AND: alu_res = red_any ? OW'(&red_operand) : OW'(cmd_q.a & cmd_q.b);
         OP_XOR: alu_res = red_any ? OW'(^red_operand) : OW'(cmd_q.a ^ cmd_q.b);
         OP_ADD: alu_res = OW'(cmd_q.a) + OW'(cmd_q.b) + OW'(cin_eff);
         OP_MUL: alu_res = OW'(cmd_q.a) * OW'(cmd_q.b);
         default: alu_res = out_q;
      endcase
   end

   always_comb begin
      step_res = out_q;
      if (cmd_q.opcode == OP_SHIFT) begin
         step_res = cmd_q.direction ? {cmd_q.serial_in, out_q[OW-1:1]}
                                    : {out_q[OW-2:0], cmd_q.serial_in};
      end else begin
         step_res = cmd_q.direction ? {out_q[OW-2:0], out_q[OW-1]}
                                    : {out_q[0], out_q[OW-1:1]};
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      step_d      = step_q;
      blink_set   = 1'b0;
      blink_clr   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cmd_d.a         = A;
               cmd_d.b         = B;
               cmd_d.opcode    = opcode;
               cmd_d.cin       = cin;
               cmd_d.serial_in = serial_in;
               cmd_d.direction = direction;
               cmd_d.red_a     = red_op_A;
               cmd_d.red_b     = red_op_B;
               cmd_d.byp_a     = bypass_A;
               cmd_d.byp_b     = bypass_B;
               cmd_d.shamt     = shamt;
               state_d         = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_IDLE;
            if (invalid) begin
               out_d       = '0;
               out_valid_d = 1'b1;
               err_d       = 1'b1;
               blink_set   = 1'b1;
            end else if (bypass) begin
               out_d       = OW'(byp_val);
               out_valid_d = 1'b1;
               blink_clr   = 1'b1;
            end else if (is_shift) begin
               if (cmd_q.shamt == '0) begin
                  out_valid_d = 1'b1;
                  blink_clr   = 1'b1;
               end else begin
                  step_d  = cmd_q.shamt;
                  state_d = S_STEP;
               end
            end else begin
               out_d       = alu_res;
               out_valid_d = 1'b1;
               blink_clr   = 1'b1;
            end
         end
         S_STEP: begin
            out_d  = step_res;
            step_d = step_q - SW'(1);
            if (step_q == SW'(1)) begin
               out_valid_d = 1'b1;
               blink_clr   = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         step_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         step_q      <= step_d;
      end
   end

   alsu_blink #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink (
      .clk     (clk),
      .rst     (rst),
      .set_i   (blink_set),
      .clear_i (blink_clr),
      .leds_o  (leds)
   );

   assign in_ready  = (state_q == S_IDLE);
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;

endmodule
